// File: rtl/peak_pkg.sv
// Shared types and defaults for the stream peak detector.
// Holds the FSM state enum and the default sample/index widths.
package peak_pkg;

  localparam int DEF_S = 8;
  localparam int DEF_N = 16;

  localparam int SAMPLE_W = DEF_S;
  localparam int IDX_W    = $clog2(DEF_N);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [IDX_W-1:0]    index_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator: eq = (a == b), gt = (a > b).
// Purely combinational, zero latency, no flow control.
module mag_cmp #(
  parameter int S = 8
) (
  input  logic [S-1:0] a,
  input  logic [S-1:0] b,
  output logic         eq,
  output logic         gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/stream_peak_detector.sv
// Frame peak detector: max/first-index/all-equal over N samples (min tracking with PEAK_MIN_EN).
// Latency: result valid the cycle after the N-th accept; in_ready=0 while the result is held.
// Backpressure: out_ready low holds the result and stalls the input indefinitely.
module stream_peak_detector
  import peak_pkg::*;
#(
  parameter  int S  = DEF_S,
  parameter  int N  = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [S-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [S-1:0]  out_max,
  output logic [IW-1:0] out_max_idx,
`ifdef PEAK_MIN_EN
  output logic [S-1:0]  out_min,
  output logic [IW-1:0] out_min_idx,
`endif
  output logic          out_all_eq
);

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [S-1:0]  max_q, max_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [S-1:0]  first_q, first_d;
  logic          all_eq_q, all_eq_d;

  logic accept;
  logic max_gt, unused_max_eq;
  logic first_eq, unused_first_gt;

  mag_cmp #(.S(S)) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .eq (unused_max_eq),
    .gt (max_gt)
  );

  mag_cmp #(.S(S)) u_cmp_first (
    .a  (in_data),
    .b  (first_q),
    .eq (first_eq),
    .gt (unused_first_gt)
  );

`ifdef PEAK_MIN_EN
  logic [S-1:0]  min_q, min_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic          min_gt, unused_min_eq;

  // min_q > in_data means the new sample is strictly smaller.
  mag_cmp #(.S(S)) u_cmp_min (
    .a  (min_q),
    .b  (in_data),
    .eq (unused_min_eq),
    .gt (min_gt)
  );
`endif

  // Gated by rst so the input looks stalled while reset is held.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    first_d   = first_q;
    all_eq_d  = all_eq_q;
`ifdef PEAK_MIN_EN
    min_d     = min_q;
    min_idx_d = min_idx_q;
`endif

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == '0) begin
            max_d     = in_data;
            max_idx_d = '0;
            first_d   = in_data;
            all_eq_d  = 1'b1;
`ifdef PEAK_MIN_EN
            min_d     = in_data;
            min_idx_d = '0;
`endif
          end else begin
            // Strict compares only: ties keep the earliest index.
            if (max_gt) begin
              max_d     = in_data;
              max_idx_d = cnt_q;
            end
            if (!first_eq) begin
              all_eq_d = 1'b0;
            end
`ifdef PEAK_MIN_EN
            if (min_gt) begin
              min_d     = in_data;
              min_idx_d = cnt_q;
            end
`endif
          end

          if (cnt_q == IW'(N - 1)) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      first_q   <= '0;
      all_eq_q  <= 1'b0;
`ifdef PEAK_MIN_EN
      min_q     <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      first_q   <= first_d;
      all_eq_q  <= all_eq_d;
`ifdef PEAK_MIN_EN
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  assign out_max     = max_q;
  assign out_max_idx = max_idx_q;
  assign out_all_eq  = all_eq_q;
`ifdef PEAK_MIN_EN
  assign out_min     = min_q;
  assign out_min_idx = min_idx_q;
`endif

endmodule

// File: tb/tb_stream_peak_detector.sv
// Directed bench for stream_peak_detector with S=8, N=4; min checks compile in with PEAK_MIN_EN.
module tb_stream_peak_detector;

  localparam int S  = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [S-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [S-1:0]  out_max;
  logic [IW-1:0] out_max_idx;
  logic          out_all_eq;
`ifdef PEAK_MIN_EN
  logic [S-1:0]  out_min;
  logic [IW-1:0] out_min_idx;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stream_peak_detector #(.S(S), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_max     (out_max),
    .out_max_idx (out_max_idx),
`ifdef PEAK_MIN_EN
    .out_min     (out_min),
    .out_min_idx (out_min_idx),
`endif
    .out_all_eq  (out_all_eq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [S-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_result(input string tag, input logic [S-1:0] mx, input logic [IW-1:0] mi,
                              input logic ae, input logic [S-1:0] mn, input logic [IW-1:0] ni);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_max"}, 32'(out_max), 32'(mx));
    check({tag, "_max_idx"}, 32'(out_max_idx), 32'(mi));
    check({tag, "_all_eq"}, 32'(out_all_eq), 32'(ae));
`ifdef PEAK_MIN_EN
    check({tag, "_min"}, 32'(out_min), 32'(mn));
    check({tag, "_min_idx"}, 32'(out_min_idx), 32'(ni));
`else
    if (mn != mn || ni != ni) $display("unreachable");
`endif
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_max", 32'(out_max), 32'd0);
    check("rst_out_max_idx", 32'(out_max_idx), 32'd0);
    check("rst_out_all_eq", 32'(out_all_eq), 32'd0);
`ifdef PEAK_MIN_EN
    check("rst_out_min", 32'(out_min), 32'd0);
    check("rst_out_min_idx", 32'(out_min_idx), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Frame 1: back-to-back, result taken immediately.
    out_ready = 1'b1;
    push(8'd3);
    push(8'd9);
    push(8'd1);
    check("f1_not_yet_valid", 32'(out_valid), 32'd0);
    push(8'd9);
    check_result("f1", 8'd9, 2'd1, 1'b0, 8'd1, 2'd2);
    step();
    check("f1_taken_valid", 32'(out_valid), 32'd0);
    check("f1_taken_in_ready", 32'(in_ready), 32'd1);

    // Frame 2: all samples equal.
    for (int i = 0; i < N; i++) push(8'hA5);
    check_result("f2", 8'hA5, 2'd0, 1'b1, 8'hA5, 2'd0);
    step();

    // Frame 3: unsigned boundaries, result held with junk offered on the input.
    out_ready = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h80);
    push(8'hFF);
    check_result("f3", 8'hFF, 2'd1, 1'b0, 8'h00, 2'd0);
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int i = 0; i < 5; i++) begin
      step();
      check("f3_hold_valid", 32'(out_valid), 32'd1);
      check("f3_hold_in_ready", 32'(in_ready), 32'd0);
      check("f3_hold_max", 32'(out_max), 32'hFF);
      check("f3_hold_max_idx", 32'(out_max_idx), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("f3_release_valid", 32'(out_valid), 32'd0);
    check("f3_release_in_ready", 32'(in_ready), 32'd1);

    // Frame 4: frame 1 data with idle cycles between samples.
    push(8'd3);
    step();
    push(8'd9);
    step();
    push(8'd1);
    step();
    check("f4_gap_not_valid", 32'(out_valid), 32'd0);
    push(8'd9);
    check_result("f4", 8'd9, 2'd1, 1'b0, 8'd1, 2'd2);
    step();

    // Partial frame aborted by reset, then a fresh frame.
    push(8'd7);
    push(8'd7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_max", 32'(out_max), 32'd0);
    out_ready = 1'b0;
    push(8'd5);
    push(8'd6);
    check("abort_cnt_cleared", 32'(out_valid), 32'd0);
    push(8'd7);
    push(8'd8);
    check_result("f5", 8'd8, 2'd3, 1'b0, 8'd5, 2'd0);

    // Reset while holding a result drops out_valid without a handshake.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    step();
    check("hold_rst_valid2", 32'(out_valid), 32'd0);
    check("hold_rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
